// File: rtl/lane_tx_scheduler.sv
// Transmit scheduler for the four-lane byte link: COM training until lock,
// round-robin payload arbitration, and IDLE/SKP control symbol insertion.
module lane_tx_scheduler #(
    parameter int unsigned COM_COUNT   = 4,
    parameter int unsigned SKIP_PERIOD = 16,
    parameter int unsigned IDLE_LIMIT  = 8,
    parameter logic [7:0]  COM_SYM     = 8'hBC,
    parameter logic [7:0]  IDLE_SYM    = 8'h7C,
    parameter logic [7:0]  SKP_SYM     = 8'h1C
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_0,
    input  logic [7:0] data_1,
    input  logic [7:0] data_2,
    input  logic [7:0] data_3,
    input  logic       valid_0,
    input  logic       valid_1,
    input  logic       valid_2,
    input  logic       valid_3,
    output logic       ready_0,
    output logic       ready_1,
    output logic       ready_2,
    output logic       ready_3,
    input  logic       active_rx,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       k_out,
    output logic [1:0] lane_out,
    output logic       idle_out,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        TRAIN  = 2'b00,
        ACTIVE = 2'b01
    } state_t;

    localparam logic [7:0] COM_MAX  = 8'(COM_COUNT);
    localparam logic [7:0] SKP_LAST = 8'(SKIP_PERIOD - 1);
    localparam logic [7:0] IDLE_MAX = 8'(IDLE_LIMIT);

    state_t     state;
    logic [7:0] com_cnt;
    logic [7:0] skp_cnt;
    logic [7:0] idle_cnt;
    logic [1:0] last;

    logic [3:0] valid_vec;
    logic [3:0] grant;
    logic [1:0] grant_lane;
    logic [1:0] scan;
    logic       grant_any;
    logic       skp_slot;
    logic       can_grant;
    logic [7:0] sel_data;

    assign valid_vec = {valid_3, valid_2, valid_1, valid_0};
    assign skp_slot  = (skp_cnt == SKP_LAST);
    assign can_grant = !reset && (state == ACTIVE) && active_rx && !skp_slot;

    // Scan last+1 .. last+4 (mod 4); the fourth step revisits `last` itself.
    always_comb begin
        grant      = '0;
        grant_lane = last;
        grant_any  = 1'b0;
        scan       = last;
        for (int unsigned k = 1; k <= 4; k++) begin
            scan = last + 2'(k);
            if (!grant_any && valid_vec[scan]) begin
                grant_any  = 1'b1;
                grant_lane = scan;
            end
        end
        if (can_grant && grant_any) begin
            grant[grant_lane] = 1'b1;
        end
    end

    assign ready_0 = grant[0];
    assign ready_1 = grant[1];
    assign ready_2 = grant[2];
    assign ready_3 = grant[3];

    always_comb begin
        sel_data = data_0;
        case (grant_lane)
            2'd0: sel_data = data_0;
            2'd1: sel_data = data_1;
            2'd2: sel_data = data_2;
            2'd3: sel_data = data_3;
            default: sel_data = data_0;
        endcase
    end

    assign state_out = state;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state     <= TRAIN;
            com_cnt   <= '0;
            skp_cnt   <= '0;
            idle_cnt  <= '0;
            last      <= 2'd3;
            data_out  <= '0;
            valid_out <= 1'b0;
            k_out     <= 1'b0;
            lane_out  <= '0;
            idle_out  <= 1'b0;
        end else begin
            case (state)
                TRAIN: begin
                    valid_out <= 1'b0;
                    k_out     <= 1'b1;
                    idle_out  <= 1'b0;
                    // The entry edge emits an IDLE filler so exactly COM_COUNT COMs lead.
                    if (com_cnt == COM_MAX && active_rx) begin
                        state    <= ACTIVE;
                        com_cnt  <= '0;
                        skp_cnt  <= '0;
                        idle_cnt <= '0;
                        data_out <= IDLE_SYM;
                    end else begin
                        data_out <= COM_SYM;
                        if (com_cnt != COM_MAX) begin
                            com_cnt <= com_cnt + 8'd1;
                        end
                    end
                end
                ACTIVE: begin
                    if (!active_rx) begin
                        state     <= TRAIN;
                        com_cnt   <= '0;
                        data_out  <= COM_SYM;
                        valid_out <= 1'b0;
                        k_out     <= 1'b1;
                        idle_out  <= 1'b0;
                    end else if (skp_slot) begin
                        skp_cnt   <= '0;
                        data_out  <= SKP_SYM;
                        valid_out <= 1'b0;
                        k_out     <= 1'b1;
                    end else begin
                        skp_cnt <= skp_cnt + 8'd1;
                        if (grant_any) begin
                            data_out  <= sel_data;
                            valid_out <= 1'b1;
                            k_out     <= 1'b0;
                            lane_out  <= grant_lane;
                            last      <= grant_lane;
                            idle_cnt  <= '0;
                            idle_out  <= 1'b0;
                        end else begin
                            data_out  <= IDLE_SYM;
                            valid_out <= 1'b0;
                            k_out     <= 1'b1;
                            if (idle_cnt != IDLE_MAX) begin
                                idle_cnt <= idle_cnt + 8'd1;
                                idle_out <= (idle_cnt + 8'd1 == IDLE_MAX);
                            end
                        end
                    end
                end
                default: begin
                    state <= TRAIN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Self-checking bench for lane_tx_scheduler: directed scenarios plus random
// traffic, all compared against a lane/slot-level reference model.
module tb_lane_tx_scheduler;

    localparam int COM_COUNT   = 4;
    localparam int SKIP_PERIOD = 16;
    localparam int IDLE_LIMIT  = 8;
    localparam logic [7:0] COM_SYM  = 8'hBC;
    localparam logic [7:0] IDLE_SYM = 8'h7C;
    localparam logic [7:0] SKP_SYM  = 8'h1C;

    logic       clk_4f = 1'b0;
    logic       reset = 1'b1;
    logic       active_rx = 1'b0;
    logic [3:0] vld = '0;
    logic [7:0] dat [4];
    logic       ready_0, ready_1, ready_2, ready_3;
    logic [7:0] data_out;
    logic       valid_out, k_out, idle_out;
    logic [1:0] lane_out, state_out;

    logic [3:0]  rdy;
    logic [14:0] obs;
    assign rdy = {ready_3, ready_2, ready_1, ready_0};
    assign obs = {data_out, valid_out, k_out, lane_out, idle_out, state_out};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_4f = ~clk_4f;

    lane_tx_scheduler #(
        .COM_COUNT(COM_COUNT), .SKIP_PERIOD(SKIP_PERIOD), .IDLE_LIMIT(IDLE_LIMIT),
        .COM_SYM(COM_SYM), .IDLE_SYM(IDLE_SYM), .SKP_SYM(SKP_SYM)
    ) dut (
        .clk_4f(clk_4f), .reset(reset),
        .data_0(dat[0]), .data_1(dat[1]), .data_2(dat[2]), .data_3(dat[3]),
        .valid_0(vld[0]), .valid_1(vld[1]), .valid_2(vld[2]), .valid_3(vld[3]),
        .ready_0(ready_0), .ready_1(ready_1), .ready_2(ready_2), .ready_3(ready_3),
        .active_rx(active_rx), .data_out(data_out), .valid_out(valid_out),
        .k_out(k_out), .lane_out(lane_out), .idle_out(idle_out), .state_out(state_out)
    );

    // Reference model: link phase, COMs sent, ACTIVE cycles since entry,
    // last served lane and length of the current idle run.
    int m_train = 1, m_coms = 0, m_act_n = 0, m_last = 3, m_idle_run = 0;
    logic [7:0] e_data = '0;
    logic       e_valid = 1'b0, e_k = 1'b0, e_idle = 1'b0;
    logic [1:0] e_lane = '0, e_state = '0;

    function automatic int m_pick();
        for (int off = 1; off <= 4; off++) begin
            int l;
            l = (m_last + off) % 4;
            if (vld[l]) return l;
        end
        return -1;
    endfunction

    function automatic bit m_skp_due();
        return (m_act_n % SKIP_PERIOD) == SKIP_PERIOD - 1;
    endfunction

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        int g;
        r = '0;
        g = m_pick();
        if (!reset && m_train == 0 && active_rx && !m_skp_due() && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [14:0] exp_pack();
        return {e_data, e_valid, e_k, e_lane, e_idle, e_state};
    endfunction

    always @(posedge clk_4f) begin
        int g;
        g = m_pick();
        if (reset) begin
            m_train = 1; m_coms = 0; m_act_n = 0; m_last = 3; m_idle_run = 0;
            e_data = '0; e_valid = 0; e_k = 0; e_lane = '0; e_idle = 0; e_state = 2'b00;
        end else if (m_train != 0) begin
            e_valid = 0; e_k = 1; e_idle = 0;
            if (m_coms == COM_COUNT && active_rx) begin
                m_train = 0; m_coms = 0; m_act_n = 0; m_idle_run = 0;
                e_data = IDLE_SYM; e_state = 2'b01;
            end else begin
                e_data = COM_SYM;
                if (m_coms < COM_COUNT) m_coms++;
            end
        end else if (!active_rx) begin
            m_train = 1; m_coms = 0;
            e_data = COM_SYM; e_valid = 0; e_k = 1; e_idle = 0; e_state = 2'b00;
        end else if (m_skp_due()) begin
            m_act_n++;
            e_data = SKP_SYM; e_valid = 0; e_k = 1;
        end else begin
            m_act_n++;
            if (g >= 0) begin
                e_data = dat[g]; e_valid = 1; e_k = 0; e_lane = 2'(g);
                m_last = g; m_idle_run = 0;
            end else begin
                e_data = IDLE_SYM; e_valid = 0; e_k = 1;
                if (m_idle_run < IDLE_LIMIT) m_idle_run++;
            end
            e_idle = (m_idle_run == IDLE_LIMIT);
        end
    end

    task automatic test_reset();
        reset = 1; active_rx = 1; vld = 4'hF;
        repeat (2) @(posedge clk_4f);
        @(negedge clk_4f);
        n_checks++;
        if (obs !== 15'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 15'h0);
        end
        #1;
        n_checks++;
        if (rdy !== 4'h0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected %b", rdy, 4'h0);
        end
    endtask

    task automatic test_bringup();
        int com_seen, first_idle;
        com_seen = 0; first_idle = -1;
        reset = 1; active_rx = 1; vld = '0;
        repeat (2) @(posedge clk_4f);
        @(negedge clk_4f);
        reset = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_4f);
            n_checks++;
            if (obs !== exp_pack()) begin
                n_fail++; $display("FAIL bringup_out: got %h expected %h", obs, exp_pack());
            end
            if (state_out == 2'b00 && k_out && data_out == COM_SYM) com_seen++;
            if (idle_out && first_idle < 0) first_idle = i;
            #1;
            n_checks++;
            if (rdy !== model_ready()) begin
                n_fail++; $display("FAIL bringup_ready: got %b expected %b", rdy, model_ready());
            end
        end
        n_checks++;
        if (com_seen != COM_COUNT) begin
            n_fail++; $display("FAIL bringup_com_count: got %0d expected %0d", com_seen, COM_COUNT);
        end
        n_checks++;
        if (first_idle != COM_COUNT + IDLE_LIMIT) begin
            n_fail++;
            $display("FAIL bringup_idle_rise: got %0d expected %0d", first_idle, COM_COUNT + IDLE_LIMIT);
        end
    endtask

    task automatic test_late_lock();
        reset = 1; active_rx = 0; vld = 4'hF;
        for (int i = 0; i < 4; i++) dat[i] = 8'(8'h10 + i);
        repeat (2) @(posedge clk_4f);
        @(negedge clk_4f);
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_4f);
            n_checks++;
            if (obs !== exp_pack() || data_out !== COM_SYM) begin
                n_fail++; $display("FAIL late_lock_com: got %h expected %h", obs, exp_pack());
            end
            #1;
            n_checks++;
            if (rdy !== 4'h0) begin
                n_fail++; $display("FAIL late_lock_ready: got %b expected %b", rdy, 4'h0);
            end
        end
        active_rx = 1;
        @(negedge clk_4f);
        n_checks++;
        if (state_out !== 2'b01 || obs !== exp_pack()) begin
            n_fail++; $display("FAIL late_lock_active: got %h expected %h", obs, exp_pack());
        end
    endtask

    task automatic test_round_robin();
        int prev, last_skp;
        prev = -1; last_skp = -1;
        dat[0] = 8'hFF; dat[1] = 8'hEE; dat[2] = 8'hDD; dat[3] = 8'hCC;
        vld = 4'hF;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk_4f);
            n_checks++;
            if (obs !== exp_pack()) begin
                n_fail++; $display("FAIL rr_out: got %h expected %h", obs, exp_pack());
            end
            if (valid_out === 1'b1) begin
                if (prev >= 0) begin
                    n_checks++;
                    if (int'(lane_out) != (prev + 1) % 4) begin
                        n_fail++; $display("FAIL rr_order: got %0d expected %0d", lane_out, (prev + 1) % 4);
                    end
                end
                prev = int'(lane_out);
            end else if (k_out === 1'b1 && data_out === SKP_SYM) begin
                if (last_skp >= 0) begin
                    n_checks++;
                    if (i - last_skp != SKIP_PERIOD) begin
                        n_fail++; $display("FAIL rr_skp_spacing: got %0d expected %0d", i - last_skp, SKIP_PERIOD);
                    end
                end
                last_skp = i;
            end
            #1;
            n_checks++;
            if (rdy !== model_ready()) begin
                n_fail++; $display("FAIL rr_ready: got %b expected %b", rdy, model_ready());
            end
        end
        n_checks++;
        if (last_skp < 0) begin
            n_fail++; $display("FAIL rr_skp_seen: got none expected %h", SKP_SYM);
        end
    endtask

    task automatic test_sparse();
        vld = 4'b0100; dat[2] = 8'h77;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_4f);
            n_checks++;
            if (obs !== exp_pack() || idle_out !== 1'b0) begin
                n_fail++; $display("FAIL sparse_out: got %h expected %h", obs, exp_pack());
            end
            #1;
            n_checks++;
            if (rdy !== model_ready() || (rdy !== 4'b0100 && rdy !== 4'b0000)) begin
                n_fail++; $display("FAIL sparse_ready: got %b expected %b", rdy, model_ready());
            end
        end
        vld = '0;
        for (int i = 0; i < IDLE_LIMIT + 2; i++) begin
            @(negedge clk_4f);
            n_checks++;
            if (obs !== exp_pack()) begin
                n_fail++; $display("FAIL sparse_idle_out: got %h expected %h", obs, exp_pack());
            end
        end
        n_checks++;
        if (idle_out !== 1'b1) begin
            n_fail++; $display("FAIL sparse_idle_high: got %b expected 1", idle_out);
        end
    endtask

    task automatic test_loss_of_lock();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_4f);
            n_checks++;
            if (obs !== exp_pack()) begin
                n_fail++; $display("FAIL lol_pre_out: got %h expected %h", obs, exp_pack());
            end
            vld = 4'($urandom);
            for (int l = 0; l < 4; l++) dat[l] = 8'($urandom);
        end
        @(negedge clk_4f);
        vld = 4'hF;
        active_rx = 0;
        #1;
        n_checks++;
        if (rdy !== 4'h0) begin
            n_fail++; $display("FAIL lol_ready: got %b expected %b", rdy, 4'h0);
        end
        @(negedge clk_4f);
        active_rx = 1;
        n_checks++;
        if (data_out !== COM_SYM || state_out !== 2'b00 || obs !== exp_pack()) begin
            n_fail++; $display("FAIL lol_com: got %h expected %h", obs, exp_pack());
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_4f);
            n_checks++;
            if (obs !== exp_pack()) begin
                n_fail++; $display("FAIL lol_post_out: got %h expected %h", obs, exp_pack());
            end
            vld = 4'($urandom);
            for (int l = 0; l < 4; l++) dat[l] = 8'($urandom);
            #1;
            n_checks++;
            if (rdy !== model_ready()) begin
                n_fail++; $display("FAIL lol_post_ready: got %b expected %b", rdy, model_ready());
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_lane;
        first_lane = -1;
        active_rx = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_4f);
            vld = 4'($urandom);
            for (int l = 0; l < 4; l++) dat[l] = 8'($urandom);
        end
        @(negedge clk_4f);
        vld = 4'hF;
        reset = 1;
        #1;
        n_checks++;
        if (rdy !== 4'h0) begin
            n_fail++; $display("FAIL rst_mid_ready: got %b expected %b", rdy, 4'h0);
        end
        @(negedge clk_4f);
        n_checks++;
        if (obs !== 15'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h expected %h", obs, 15'h0);
        end
        reset = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_4f);
            n_checks++;
            if (obs !== exp_pack()) begin
                n_fail++; $display("FAIL rst_mid_out: got %h expected %h", obs, exp_pack());
            end
            if (valid_out === 1'b1 && first_lane < 0) first_lane = int'(lane_out);
        end
        n_checks++;
        if (first_lane != 0) begin
            n_fail++; $display("FAIL rst_mid_first_lane: got %0d expected 0", first_lane);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_4f);
            n_checks++;
            if (obs !== exp_pack()) begin
                n_fail++; $display("FAIL rand_out: got %h expected %h", obs, exp_pack());
            end
            reset     = ($urandom_range(63) == 0);
            active_rx = ($urandom_range(23) != 0);
            vld       = 4'($urandom);
            for (int l = 0; l < 4; l++) dat[l] = 8'($urandom);
            #1;
            n_checks++;
            if (rdy !== model_ready() || (rdy & ~vld) !== 4'h0 || $countones(rdy) > 1) begin
                n_fail++; $display("FAIL rand_ready: got %b expected %b", rdy, model_ready());
            end
        end
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int l = 0; l < 4; l++) dat[l] = '0;
        test_reset();
        test_bringup();
        test_late_lock();
        test_round_robin();
        test_sparse();
        test_loss_of_lock();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_tx_scheduler.md
# lane_tx_scheduler

Transmit-side controller for the four-lane byte link. It shares one 8-bit symbol channel, feeding the parallel-to-serial stage, among lanes 0–3 with round-robin arbitration. It sequences link bring-up by sending COM training symbols until the receiver reports `active`, and inserts IDLE and SKP control symbols. It sits between the lane data sources and the serializer, in the `clk_4f` domain.

## Interface
- `COM_COUNT`, default 4: minimum number of COM symbols sent before leaving TRAIN.
- `SKIP_PERIOD`, default 16: ACTIVE cycles per SKP insertion; legal range 2–255.
- `IDLE_LIMIT`, default 8: consecutive idle cycles before `idle_out` asserts; legal range 1–255.
- `COM_SYM`, default 8'hBC: training symbol.
- `IDLE_SYM`, default 8'h7C: idle filler symbol.
- `SKP_SYM`, default 8'h1C: skip symbol.

Ports:
- `clk_4f` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `data_0` … `data_3` in 8 each: lane payload bytes.
- `valid_0` … `valid_3` in 1 each: lane has a byte to send.
- `ready_0` … `ready_3` out 1 each: grant. A transfer happens on lane i when `valid_i && ready_i` at a clock edge.
- `active_rx` in 1: receiver reports symbol lock.
- `data_out` out 8: symbol to the serializer.
- `valid_out` out 1: `data_out` is a payload byte.
- `k_out` out 1: `data_out` is a control symbol (COM, IDLE or SKP).
- `lane_out` out 2: source lane of the payload byte.
- `idle_out` out 1: link has been idle for `IDLE_LIMIT` consecutive cycles.
- `state_out` out 2: current FSM state; 2'b00 = TRAIN, 2'b01 = ACTIVE.

## Operation
- **Reset** (any edge with `reset` = 1): state TRAIN, `com_cnt` = 0, `skp_cnt` = 0, `idle_cnt` = 0, round-robin pointer `last` = 3 (lane 0 has first priority).
  - Outputs after reset: `data_out` = 8'h00, `valid_out` = 0, `k_out` = 0, `lane_out` = 0, `idle_out` = 0, `state_out` = 2'b00.
  - Reset asserted mid-operation discards any in-flight grant. No transfer is accepted on an edge where `reset` = 1.
- **TRAIN:**
  - Every cycle: `data_out` = `COM_SYM`, `k_out` = 1, `valid_out` = 0. All `ready_i` = 0.
  - `com_cnt` increments each cycle and saturates at `COM_COUNT`.
  - Go to ACTIVE when `com_cnt` == `COM_COUNT` and `active_rx` = 1 on the same edge. `com_cnt`, `skp_cnt` and `idle_cnt` clear on entry.
- **ACTIVE:**
  - If `active_rx` = 0: all `ready_i` = 0. Next state is TRAIN, `com_cnt` clears, and the next output is COM.
  - Else if `skp_cnt` == `SKIP_PERIOD`-1: all `ready_i` = 0 and the next output is `SKP_SYM` with `k_out` = 1. `skp_cnt` wraps to 0. `idle_cnt` is unchanged.
  - Otherwise, the grant goes to the first valid lane scanning `last`+1, `last`+2, … modulo 4. Exactly one `ready_i` = 1, combinational in the same cycle.
    - On the transfer: the next output is `data_out` = that lane's byte, `valid_out` = 1, `k_out` = 0, `lane_out` = lane. `last` is set to that lane and `idle_cnt` clears.
    - With no valid lanes: the next output is `IDLE_SYM`, `k_out` = 1, `valid_out` = 0. `idle_cnt` increments, saturating at `IDLE_LIMIT`.
    - `skp_cnt` increments in both cases.
- `idle_out` is registered and equals (`idle_cnt` == `IDLE_LIMIT`). It is forced to 0 in TRAIN.
- `lane_out` holds its last value on control-symbol cycles.
- `ready_i` never asserts while `valid_i` = 0. Every accepted byte appears exactly once on `data_out`; none is dropped or duplicated.

## Timing
- Latency: a transfer at edge n produces `data_out`/`valid_out`/`lane_out` visible after edge n, held for one cycle.
- `ready_i` is combinational from state, `active_rx`, `skp_cnt`, `last` and the `valid` inputs. It introduces no path from `data_*` to any ready.
- Sustained throughput: one payload byte per cycle, except one SKP slot per `SKIP_PERIOD` ACTIVE cycles.
- Fairness: with all four lanes continuously valid, grants go 0,1,2,3,0,… A SKP slot does not advance `last`.
- `active_rx` dropping on the same edge as a SKP slot: the TRAIN transition wins and the next output is COM.
- Leaving reset with `active_rx` already high: first ACTIVE cycle is the `COM_COUNT`+1-th cycle after reset release; exactly `COM_COUNT` COM symbols precede the first ACTIVE-state symbol.

## Test plan
- **Bring-up:** reset for 2 cycles, `active_rx` = 1, defaults. Expect 4 COM (8'hBC, k = 1), then `state_out` = 01. With no valids, IDLE 8'h7C follows, and `idle_out` rises after 8 IDLE cycles.
- **Late lock:** `active_rx` rises 10 cycles after reset. Expect COM for all 10 cycles with no `ready` asserted, then ACTIVE.
- **Round robin:** all valids high, data 8'hFF/8'hEE/8'hDD/8'hCC. Expect `data_out` sequence FF,EE,DD,CC,FF… with `lane_out` 0,1,2,3,…, and a 8'h1C SKP as every 16th ACTIVE symbol, after which lane order resumes without skipping a lane.
- **Sparse lanes:** only `valid_2` high (8'h77). Expect `ready_2` = 1 on every non-SKP cycle, `lane_out` = 2, `idle_out` = 0. Dropping `valid_2` yields IDLE symbols, and `idle_out` = 1 after 8 of them.
- **Loss of lock:** drop `active_rx` mid-stream. Expect all `ready` = 0 that cycle and COM on the next output. Reacquire after 4 COM; the last accepted byte is not resent.
- **Reset mid-stream:** assert `reset` during transfers. The next cycle shows the reset values, `state_out` = 00, and lane 0 has first priority after retraining.
